// File: rtl/rca_pkg.sv
// Shared definitions for the ripple-carry adder result accumulator.
package rca_pkg;

    localparam int SUM_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        FULL
    } acc_state_t;

endpackage

// File: rtl/rca_sat_add.sv
// Accumulator adder: acc + zero-extended sum, reports the carry out of ACC_W bits.
// RCA_ACC_SAT_EN clamps the result to all-ones on carry; otherwise it wraps.
module rca_sat_add
    import rca_pkg::*;
#(
    parameter int ACC_W = 8
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [SUM_W-1:0] sum,
    output logic [ACC_W-1:0] acc_next,
    output logic             carry
);

    logic [ACC_W:0] wide;

    assign wide  = {1'b0, acc} + {{(ACC_W + 1 - SUM_W){1'b0}}, sum};
    assign carry = wide[ACC_W];

`ifdef RCA_ACC_SAT_EN
    // Once clamped, any further non-zero sum carries again, so the clamp holds.
    assign acc_next = carry ? '1 : wide[ACC_W-1:0];
`else
    assign acc_next = wide[ACC_W-1:0];
`endif

endmodule

// File: rtl/rca_sum_accumulator.sv
// Sums BATCH adder results and offers each total on a valid/ready port.
// Overflow behaviour selected by RCA_ACC_SAT_EN (see rca_sat_add).
module rca_sum_accumulator
    import rca_pkg::*;
#(
    parameter int ACC_W = 8,
    parameter int BATCH = 8,
    localparam int CNT_W = $clog2(BATCH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [SUM_W-1:0] in_sum,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_total,
    output logic             out_ovf,
    output logic [CNT_W-1:0] count
);

    acc_state_t       state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic             carry;
    logic             ovf;

    rca_sat_add #(
        .ACC_W(ACC_W)
    ) u_add (
        .acc     (acc),
        .sum     (in_sum),
        .acc_next(acc_next),
        .carry   (carry)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (in_valid) begin
                        acc   <= acc_next;
                        ovf   <= ovf | carry;
                        count <= count + CNT_W'(1);
                        if (count == CNT_W'(BATCH - 1)) begin
                            state     <= FULL;
                            out_valid <= 1'b1;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        acc       <= '0;
                        count     <= '0;
                        ovf       <= 1'b0;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    acc       <= '0;
                    count     <= '0;
                    ovf       <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // The running accumulator doubles as the output register; it is only meaningful in FULL.
    assign out_total = acc;
    assign out_ovf   = ovf;
    assign in_ready  = (state != FULL);

endmodule

// File: tb/tb_rca_sum_accumulator.sv
// Scoreboard bench for rca_sum_accumulator: three configurations (8/8, 6/4, 8/1) share stimulus.
module tb_rca_sum_accumulator;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       in_valid  [3];
    logic [4:0] in_sum    [3];
    logic       out_ready [3];
    logic       in_ready  [3];
    logic       out_valid [3];
    logic       out_ovf   [3];
    logic [7:0] out_total [3];
    logic [3:0] count_v   [3];

    logic [7:0] tot0, tot2;
    logic [5:0] tot1;
    logic [3:0] cnt0;
    logic [2:0] cnt1;
    logic [0:0] cnt2;

    assign out_total[0] = tot0;
    assign out_total[1] = {2'b00, tot1};
    assign out_total[2] = tot2;
    assign count_v[0]   = cnt0;
    assign count_v[1]   = {1'b0, cnt1};
    assign count_v[2]   = {3'b000, cnt2};

    rca_sum_accumulator #(.ACC_W(8), .BATCH(8)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_sum(in_sum[0]),
        .in_ready(in_ready[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_total(tot0), .out_ovf(out_ovf[0]), .count(cnt0)
    );
    rca_sum_accumulator #(.ACC_W(6), .BATCH(4)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_sum(in_sum[1]),
        .in_ready(in_ready[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_total(tot1), .out_ovf(out_ovf[1]), .count(cnt1)
    );
    rca_sum_accumulator #(.ACC_W(8), .BATCH(1)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_sum(in_sum[2]),
        .in_ready(in_ready[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_total(tot2), .out_ovf(out_ovf[2]), .count(cnt2)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit armed   = 1'b0;

    function automatic int acc_w(int g);
        return (g == 1) ? 6 : 8;
    endfunction

    function automatic int batch_of(int g);
        return (g == 0) ? 8 : (g == 1) ? 4 : 1;
    endfunction

    // Reference: the true (unbounded) batch sum, reduced to what the port should show.
    function automatic int exp_total(int g, int s);
        int mx = (1 << acc_w(g)) - 1;
`ifdef RCA_ACC_SAT_EN
        return (s > mx) ? mx : s;
`else
        return s % (mx + 1);
`endif
    endfunction

    function automatic void chk(string name, int g, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s[dut%0d] t=%0t got %0d expected %0d", name, g, $time, act, exp);
        end
    endfunction

    typedef struct {
        int total;
        int ovf;
    } exp_t;

    for (genvar g = 0; g < 3; g++) begin : mon
        initial begin
            exp_t q[$];
            int   m_cnt  = 0;
            int   m_sum  = 0;
            bit   m_held = 1'b0;
            forever begin
                @(negedge clk);
                if (!armed) continue;
                chk("in_ready", g, int'(in_ready[g]), int'(!m_held));
                chk("out_valid", g, int'(out_valid[g]), int'(m_held));
                chk("count", g, int'(count_v[g]), m_held ? batch_of(g) : m_cnt);
                if (out_valid[g]) begin
                    if (q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL scoreboard_empty[dut%0d] t=%0t got out_valid=1 expected no pending total", g, $time);
                    end else begin
                        chk("out_total", g, int'(out_total[g]), q[0].total);
                        chk("out_ovf", g, int'(out_ovf[g]), q[0].ovf);
                    end
                end
                if (reset) begin
                    m_cnt  = 0;
                    m_sum  = 0;
                    m_held = 1'b0;
                    q.delete();
                end else if (m_held) begin
                    if (out_ready[g]) begin
                        if (q.size() > 0) void'(q.pop_front());
                        m_held = 1'b0;
                        m_cnt  = 0;
                        m_sum  = 0;
                    end
                end else if (in_valid[g]) begin
                    m_sum += int'(in_sum[g]);
                    m_cnt++;
                    if (m_cnt == batch_of(g)) begin
                        q.push_back('{exp_total(g, m_sum), int'(m_sum >= (1 << acc_w(g)))});
                        m_held = 1'b1;
                    end
                end
            end
        end
    end

    task automatic cyc(input bit v, input logic [4:0] s, input bit r, input bit rst);
        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = v;
            in_sum[i]    = s;
            out_ready[i] = r;
        end
        reset = rst;
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [4:0] gap_vals [8];
        gap_vals = '{5'd5, 5'd0, 5'd17, 5'd2, 5'd9, 5'd31, 5'd4, 5'd12};

        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b0;
            in_sum[i]    = '0;
            out_ready[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #2;
        armed = 1'b1;
        cyc(0, 0, 1, 1);

        // Reset mid-batch
        repeat (3) cyc(1, 5'd7, 1, 0);
        cyc(0, 0, 1, 1);
        repeat (2) cyc(0, 0, 1, 0);

        // Basic batch of 31s
        repeat (8) cyc(1, 5'd31, 1, 0);
        repeat (3) cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 1);

        // Back-pressure: 1..8 then in_valid stays high while the total waits
        for (int v = 1; v <= 8; v++) cyc(1, 5'(v), 0, 0);
        repeat (5) cyc(1, 5'd3, 0, 0);
        cyc(1, 5'd3, 1, 0);
        repeat (2) cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 1);

        // Gapped input
        for (int k = 0; k < 8; k++) begin
            cyc(1, gap_vals[k], 1, 0);
            cyc(0, 5'd29, 1, 0);
        end
        repeat (3) cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 1);

        // Overflow: four 20s (dut1 reaches 80 on a 6-bit accumulator)
        repeat (4) cyc(1, 5'd20, 1, 0);
        repeat (3) cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 1);

        // Continuous stream with out_ready high (BATCH=1 alternates in_ready)
        repeat (12) cyc(1, 5'($urandom_range(0, 31)), 1, 0);

        // Randomized traffic with occasional reset
        for (int n = 0; n < 600; n++) begin
            cyc($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)),
                $urandom_range(0, 2) != 0, $urandom_range(0, 99) == 0);
        end
        repeat (4) cyc(0, 0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
